// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and layer geometry helpers
// used by the conv layer sequencer and its load/compute counters.
package conv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_B,
      S_LOAD_P,
      S_COMPUTE,
      S_DONE
   } state_t;

   // output edge length of a valid (unpadded) strided convolution
   function automatic int out_dim(input int img, input int k,
                                  input int stride);
      return (img - k) / stride + 1;
   endfunction

   function automatic int w_num(input int k, input int ch);
      return k * k * ch;
   endfunction

   function automatic int p_num(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/load_phase_counter.sv
// load_phase_counter: wrapping up-counter with clear, enable and
// a last flag (cnt == lim). Ports: clk, rst (async, active-low),
// clr, en, lim in; cnt, last out. Wraps to 0 when enabled at last.
module load_phase_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] lim,
   output logic [W-1:0] cnt,
   output logic         last
);

   assign last = (cnt == lim);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || (en && last)) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: loads weights/biases/pixels from one word
// stream into external memories, then sweeps the output map,
// issuing windows to the core and writing results.
// Ports: clk, rst (async active-low); start/reuse_params/busy/done
// frame handshake; in_valid/in_data/in_ready load stream;
// w_we/b_we/pix_we/ld_addr/ld_data memory writes; win_req/win_row/
// win_col/win_ack/res_data core side; res_we/res_addr/res_wdata.
module conv_layer_sequencer
   import conv_pkg::*;
#(
   parameter int DATA_W = 48,
   parameter int RES_W  = 128,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int K      = 3,
   parameter int STRIDE = 1,
   parameter int CH_OUT = 8,
   parameter int AW     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              reuse_params,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              w_we,
   output logic              b_we,
   output logic              pix_we,
   output logic [AW-1:0]     ld_addr,
   output logic [DATA_W-1:0] ld_data,
   output logic              win_req,
   output logic [AW-1:0]     win_row,
   output logic [AW-1:0]     win_col,
   input  logic              win_ack,
   input  logic [RES_W-1:0]  res_data,
   output logic              res_we,
   output logic [AW-1:0]     res_addr,
   output logic [RES_W-1:0]  res_wdata
);

   localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
   localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
   localparam int W_NUM = w_num(K, CH_OUT);
   localparam int B_NUM = CH_OUT;
   localparam int P_NUM = p_num(IMG_W, IMG_H);
   localparam longint ASPACE = 64'd1 << AW;

   if ((longint'(OUT_W) * OUT_H > ASPACE) ||
       (longint'(P_NUM) > ASPACE)) begin : g_size_chk
      $error("conv_layer_sequencer: AW too small");
   end

   state_t state, next_state;

   logic          accept;
   logic          phase_end;
   logic          params_valid;
   logic [AW-1:0] ld_lim;
   logic [AW-1:0] ld_cnt;
   logic          ld_last;
   logic [AW-1:0] out_row;
   logic [AW-1:0] out_col;
   logic          col_last;
   logic          row_last;

   assign accept   = in_valid && in_ready;
   assign row_last = (out_row == AW'(OUT_H - 1));

   always_comb begin
      ld_lim = AW'(P_NUM - 1);
      if (state == S_LOAD_W) begin
         ld_lim = AW'(W_NUM - 1);
      end else if (state == S_LOAD_B) begin
         ld_lim = AW'(B_NUM - 1);
      end
   end

   load_phase_counter #(.W(AW)) u_ld_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == S_IDLE),
      .en   (accept),
      .lim  (ld_lim),
      .cnt  (ld_cnt),
      .last (ld_last)
   );

   load_phase_counter #(.W(AW)) u_col_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (state != S_COMPUTE),
      .en   (res_we),
      .lim  (AW'(OUT_W - 1)),
      .cnt  (out_col),
      .last (col_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // phase_end marks the one bubble cycle after the last word of a
   // phase: in_ready drops and the FSM moves on at its end.
   always_comb begin
      next_state = state;
      busy       = 1'b1;
      done       = 1'b0;
      in_ready   = 1'b0;
      win_req    = 1'b0;
      res_we     = 1'b0;
      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               next_state = (reuse_params && params_valid) ?
                            S_LOAD_P : S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            in_ready = !phase_end;
            if (phase_end) next_state = S_LOAD_B;
         end
         S_LOAD_B: begin
            in_ready = !phase_end;
            if (phase_end) next_state = S_LOAD_P;
         end
         S_LOAD_P: begin
            in_ready = !phase_end;
            if (phase_end) next_state = S_COMPUTE;
         end
         S_COMPUTE: begin
            win_req = 1'b1;
            res_we  = win_ack;
            if (win_ack && col_last && row_last) begin
               next_state = S_DONE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_we         <= 1'b0;
         b_we         <= 1'b0;
         pix_we       <= 1'b0;
         ld_addr      <= '0;
         ld_data      <= '0;
         phase_end    <= 1'b0;
         params_valid <= 1'b0;
      end else begin
         w_we      <= accept && (state == S_LOAD_W);
         b_we      <= accept && (state == S_LOAD_B);
         pix_we    <= accept && (state == S_LOAD_P);
         phase_end <= accept && ld_last;
         if (accept) begin
            ld_addr <= ld_cnt;
            ld_data <= in_data;
         end
         if ((state == S_LOAD_B) && phase_end) begin
            params_valid <= 1'b1;
         end
      end
   end

   // the last window leaves the row as is; leaving COMPUTE clears it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_row <= '0;
      end else if (state != S_COMPUTE) begin
         out_row <= '0;
      end else if (res_we && col_last && !row_last) begin
         out_row <= out_row + AW'(1);
      end
   end

   assign win_row   = out_row * AW'(STRIDE);
   assign win_col   = out_col * AW'(STRIDE);
   assign res_addr  = out_row * AW'(OUT_W) + out_col;
   assign res_wdata = res_we ? res_data : '0;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: directed bench with a per-cycle model
// compare for the default layer plus a small stride-2 instance.
module tb_conv_layer_sequencer;

   localparam int DW = 48;
   localparam int RW = 128;
   localparam int AW = 16;
   localparam int OW = 30;
   localparam int OH = 30;
   localparam int WN = 72;
   localparam int BN = 8;
   localparam int PN = 1024;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          start = 0, reuse_params = 0, busy, done;
   logic          in_valid = 0, in_ready;
   logic [DW-1:0] in_data = '0, ld_data;
   logic          w_we, b_we, pix_we, win_req, res_we;
   logic          win_ack = 0;
   logic [AW-1:0] ld_addr, win_row, win_col, res_addr;
   logic [RW-1:0] res_data = '0, res_wdata;

   logic          s_start = 0, s_reuse = 0, s_busy, s_done;
   logic          s_in_valid = 0, s_in_ready;
   logic [DW-1:0] s_in_data = '0, s_ld_data;
   logic          s_w_we, s_b_we, s_pix_we, s_win_req, s_res_we;
   logic          s_win_ack = 0;
   logic [AW-1:0] s_ld_addr, s_win_row, s_win_col, s_res_addr;
   logic [RW-1:0] s_res_data = '0, s_res_wdata;

   conv_layer_sequencer u_dut (
      .clk(clk), .rst(rst), .start(start),
      .reuse_params(reuse_params), .busy(busy), .done(done),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .w_we(w_we), .b_we(b_we), .pix_we(pix_we),
      .ld_addr(ld_addr), .ld_data(ld_data),
      .win_req(win_req), .win_row(win_row), .win_col(win_col),
      .win_ack(win_ack), .res_data(res_data), .res_we(res_we),
      .res_addr(res_addr), .res_wdata(res_wdata)
   );

   conv_layer_sequencer #(
      .IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2), .CH_OUT(2)
   ) u_s2 (
      .clk(clk), .rst(rst), .start(s_start),
      .reuse_params(s_reuse), .busy(s_busy), .done(s_done),
      .in_valid(s_in_valid), .in_data(s_in_data),
      .in_ready(s_in_ready),
      .w_we(s_w_we), .b_we(s_b_we), .pix_we(s_pix_we),
      .ld_addr(s_ld_addr), .ld_data(s_ld_data),
      .win_req(s_win_req), .win_row(s_win_row),
      .win_col(s_win_col), .win_ack(s_win_ack),
      .res_data(s_res_data), .res_we(s_res_we),
      .res_addr(s_res_addr), .res_wdata(s_res_wdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]    kind;
      int            addr;
      logic [DW-1:0] data;
   } ld_t;

   ld_t exp_ld[$];
   int  fr_id = 0;
   int  res_idx = 0;
   int  w_cnt, b_cnt, p_cnt, r_cnt, done_cnt;
   int  last_pix;
   int  a29_row, a29_col;
   bit  flag29 = 0;

   function automatic logic [DW-1:0] wdat(input int kind, input int i);
      return {8'(kind), 8'(fr_id), 32'(i)};
   endfunction

   // model compare: load writes in phase order, windows in raster order
   always @(negedge clk) begin : mon
      ld_t e;
      if (flag29) begin
         a29_row = int'(win_row);
         a29_col = int'(win_col);
         flag29  = 0;
      end
      if (done) done_cnt++;
      if (w_we) w_cnt++;
      if (b_we) b_cnt++;
      if (pix_we) begin
         p_cnt++;
         last_pix = int'(ld_addr);
      end
      if (w_we || b_we || pix_we) begin
         if (exp_ld.size() == 0) begin
            chk("ld_extra", {w_we, b_we, pix_we}, 3'b000);
         end else begin
            e = exp_ld.pop_front();
            chk("ld_kind", {w_we, b_we, pix_we}, e.kind);
            chk("ld_addr", ld_addr, e.addr);
            chk("ld_data", ld_data, e.data);
         end
      end
      chk("res_we", res_we, win_ack && win_req);
      if (win_req) begin
         chk("win_row", win_row, (res_idx / OW));
         chk("win_col", win_col, (res_idx % OW));
      end
      if (res_we) begin
         chk("res_addr", res_addr, res_idx);
         chk("res_wdata", res_wdata, res_data);
         if (res_idx == 29) flag29 = 1;
         res_idx++;
         r_cnt++;
      end
   end

   task automatic frame(input bit reuse, input bit full,
                        input bit rnd, input int abort_at,
                        input int exp_len);
      logic [DW-1:0] words[$];
      ld_t e;
      int  ptr, cyc;
      bit  acc, seen;
      fr_id++;
      exp_ld.delete();
      w_cnt = 0; b_cnt = 0; p_cnt = 0; r_cnt = 0; done_cnt = 0;
      res_idx = 0; last_pix = -1; a29_row = -1; a29_col = -1;
      if (full) begin
         for (int i = 0; i < WN; i++) begin
            e.kind = 3'b100; e.addr = i; e.data = wdat(1, i);
            exp_ld.push_back(e); words.push_back(e.data);
         end
         for (int i = 0; i < BN; i++) begin
            e.kind = 3'b010; e.addr = i; e.data = wdat(2, i);
            exp_ld.push_back(e); words.push_back(e.data);
         end
      end
      for (int i = 0; i < PN; i++) begin
         e.kind = 3'b001; e.addr = i; e.data = wdat(3, i);
         exp_ld.push_back(e); words.push_back(e.data);
      end
      @(posedge clk); #1;
      start = 1'b1;
      reuse_params = reuse;
      @(negedge clk);
      ptr = 0; cyc = 0; acc = 0; seen = 0;
      while (!seen && cyc < 10000 && cyc != abort_at) begin
         @(posedge clk); #1;
         if (acc) ptr++;
         start    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         in_valid = (ptr < words.size()) &&
                    (!rnd || $urandom_range(0, 3) != 0);
         in_data  = {$urandom, $urandom};
         if (ptr < words.size()) in_data = words[ptr];
         win_ack  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         res_data = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         acc  = in_valid && in_ready;
         seen = done;
         cyc++;
      end
      start = 0; in_valid = 0; win_ack = 0; reuse_params = 0;
      if (abort_at >= 0) return;
      chk("done_seen", seen, 1'b1);
      if (exp_len > 0) chk("frame_len", cyc + 1, exp_len);
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_after_done", busy, 1'b0);
      chk("done_once", done_cnt, 1);
      chk("w_we_count", w_cnt, full ? 72 : 0);
      chk("b_we_count", b_cnt, full ? 8 : 0);
      chk("pix_we_count", p_cnt, 1024);
      chk("last_pix_addr", last_pix, 1023);
      chk("res_count", r_cnt, 900);
      chk("ld_left", exp_ld.size(), 0);
      chk("after29_row", a29_row, 1);
      chk("after29_col", a29_col, 0);
   endtask

   task automatic reset_mid(input string nm);
      int d0;
      win_ack  = 1'b1;
      in_valid = 1'b1;
      res_data = {4{32'hdead_beef}};
      #2;
      rst = 1'b0;
      #1;
      chk({nm, "_ctl"}, {busy, done, in_ready, w_we, b_we, pix_we,
                         win_req, res_we}, 8'h00);
      chk({nm, "_addr"}, {ld_addr, win_row, win_col, res_addr}, 64'h0);
      chk({nm, "_ld_data"}, ld_data, 0);
      chk({nm, "_res_wdata"}, res_wdata, 0);
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      win_ack = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk({nm, "_idle"}, busy, 1'b0);
      chk({nm, "_no_done"}, done_cnt, d0);
      exp_ld.delete();
   endtask

   task automatic s2_frame();
      int c3[3] = '{0, 2, 4};
      int rows[$], cols[$], addrs[$];
      int cyc, wc, bc, pc, lastp;
      bit seen;
      cyc = 0; wc = 0; bc = 0; pc = 0; lastp = -1; seen = 0;
      @(posedge clk); #1;
      s_start = 1'b1;
      @(negedge clk);
      while (!seen && cyc < 1000) begin
         @(posedge clk); #1;
         s_start    = 1'b0;
         s_in_valid = 1'b1;
         s_in_data  = DW'(cyc);
         s_win_ack  = 1'b1;
         s_res_data = RW'(cyc);
         @(negedge clk);
         if (s_res_we) begin
            rows.push_back(int'(s_win_row));
            cols.push_back(int'(s_win_col));
            addrs.push_back(int'(s_res_addr));
         end
         if (s_w_we) wc++;
         if (s_b_we) bc++;
         if (s_pix_we) begin
            pc++;
            lastp = int'(s_ld_addr);
         end
         seen = s_done;
         cyc++;
      end
      s_in_valid = 0;
      s_win_ack = 0;
      chk("s2_done", seen, 1'b1);
      chk("s2_len", cyc + 1, 98);
      chk("s2_w_count", wc, 18);
      chk("s2_b_count", bc, 2);
      chk("s2_pix_count", pc, 64);
      chk("s2_last_pix", lastp, 63);
      chk("s2_res_count", rows.size(), 9);
      for (int k = 0; k < rows.size() && k < 9; k++) begin
         chk("s2_win_row", rows[k], c3[k / 3]);
         chk("s2_win_col", cols[k], c3[k % 3]);
         chk("s2_res_addr", addrs[k], k);
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #21;
      chk("rst_ctl", {busy, done, in_ready, w_we, b_we, pix_we,
                      win_req, res_we}, 8'h00);
      chk("rst_addr", {ld_addr, win_row, win_col, res_addr}, 64'h0);
      chk("rst_data", {ld_data, res_wdata}, 0);
      #1;
      rst = 1'b1;
      // reuse requested but nothing loaded yet: full load expected
      frame(1'b1, 1'b1, 1'b0, -1, 2009);
      frame(1'b1, 1'b0, 1'b0, -1, 1927);
      frame(1'b0, 1'b1, 1'b1, -1, 0);
      frame(1'b1, 1'b0, 1'b1, -1, 0);
      frame(1'b0, 1'b1, 1'b0, 500, 0);
      reset_mid("rst_load");
      frame(1'b1, 1'b1, 1'b0, 1500, 0);
      reset_mid("rst_comp");
      frame(1'b1, 1'b1, 1'b0, -1, 2009);
      s2_frame();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Parametrised load/compute sequencer for one convolution layer. It accepts weights, biases and pixels as a single valid/ready word stream and writes them into external parameter and pixel memories. It then sweeps the output feature map, handing window coordinates to the convolution core and writing each core result into the result memory. It generalises the fixed 32x32 / 3x3 / 8-channel layer wrapper with parametrised geometry, stride, a start/done handshake and parameter reuse across frames.

## Interface
Parameters:
- DATA_W, 48, width of a load word (one weight row or one pixel word)
- RES_W, 128, width of one core result (all output channels packed)
- IMG_W, 32, input image width in pixels
- IMG_H, 32, input image height in pixels
- K, 3, kernel edge size
- STRIDE, 1, window step in both directions
- CH_OUT, 8, output channels (bias count)
- AW, 16, address width of all memory ports

Ports:
- clk  in  1  clock; every flop is rising-edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- start  in  1  begin a frame; sampled only in IDLE
- reuse_params  in  1  sampled with start; 1 = skip weight/bias load
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of frame
- in_valid  in  1  load word valid
- in_data  in  DATA_W  load word; biases use bits [15:0]
- in_ready  out  1  high in LOAD_W, LOAD_B, LOAD_P
- w_we, b_we, pix_we  out  1  write strobes for weight, bias and pixel memory
- ld_addr  out  AW  write address (word index within the current phase)
- ld_data  out  DATA_W  registered copy of the accepted in_data
- win_req  out  1  a window is pending for the core
- win_row, win_col  out  AW  top-left input coordinate of the pending window
- win_ack  in  1  core result for the pending window is valid this cycle
- res_data  in  RES_W  core result
- res_we  out  1  result memory write strobe
- res_addr  out  AW  out_row*OUT_W + out_col
- res_wdata  out  RES_W  result data to the result memory

## Operation
- Derived constants:
  - OUT_W = (IMG_W-K)/STRIDE+1
  - OUT_H = (IMG_H-K)/STRIDE+1
  - W_NUM = K*K*CH_OUT
  - B_NUM = CH_OUT
  - P_NUM = IMG_W*IMG_H
  - Defaults give 30, 30, 72, 8, 1024.
- States: IDLE, LOAD_W, LOAD_B, LOAD_P, COMPUTE, DONE.
- IDLE and start:
  - If reuse_params=0, or params_valid=0, go to LOAD_W.
  - Otherwise go to LOAD_P.
- Word acceptance:
  - A word is accepted when in_valid & in_ready.
  - A phase counter counts accepted words from 0.
  - When the last word is accepted (W_NUM-1, B_NUM-1, P_NUM-1), the counter clears and the FSM advances next cycle: LOAD_W→LOAD_B→LOAD_P→COMPUTE.
- params_valid:
  - Internal flag, set at the end of LOAD_B.
  - Cleared only by reset.
- COMPUTE:
  - Holds out_row/out_col, starting at 0,0.
  - win_row = out_row*STRIDE; win_col = out_col*STRIDE.
  - win_req is high throughout COMPUTE.
  - On win_ack, out_col increments. It wraps to 0 at OUT_W-1 and out_row increments.
  - The ack for (OUT_H-1, OUT_W-1) moves the FSM to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Ignored inputs:
  - start while busy.
  - win_ack outside COMPUTE (no res_we).
  - in_valid while in_ready=0 (no strobe).
- Widths: coordinate and address arithmetic is AW bits and unsigned. Elaboration fails if OUT_W*OUT_H or P_NUM exceeds 2^AW.

## Timing
- Reset values: all outputs 0, FSM IDLE, counters 0, params_valid 0.
- Reset mid-frame aborts immediately. There is no done pulse; after release the block is in IDLE.
- start is high in cycle t → busy is high and in_ready is high from t+1.
- Load write latency is 1 cycle. A word accepted at cycle t gives the strobe, ld_addr = counter value at t, and ld_data at t+1.
- Back-to-back acceptance is supported with no bubbles inside a phase.
- in_ready is low for exactly one cycle at each phase boundary.
- res_we = win_ack in COMPUTE, combinational:
  - res_addr is formed from the current out_row/out_col.
  - res_wdata = res_data.
  - The new window coordinates appear at the next cycle.
- win_ack held high on consecutive cycles means consecutive windows, one per cycle.
- Minimum frame, default parameters with reuse: 1 + 1024 + 1 + 900 + 1 cycles, with in_valid and win_ack held high.

## Structure
- Shared package conv_pkg holds the state enum typedef and the functions that compute OUT_W, OUT_H, W_NUM and P_NUM.
- One sub-module: load_phase_counter. It is a parametrised counter with clear and enable, plus a last-flag compare.
- It is instantiated twice: once for the load index and once for the output column. The output row uses a plain register.

## Test plan
- Default parameters, start with reuse_params=0, stream 72+8+1024 words with in_valid high → w_we 72×, b_we 8×, pix_we 1024×; last pix_we has ld_addr=1023; COMPUTE follows.
- COMPUTE with win_ack held high → 900 res_we; addresses run 0..899; the ack at res_addr 29 precedes win_row=1, win_col=0; done pulses once; busy falls the cycle after done.
- Second frame with reuse_params=1 → no w_we or b_we, 1024 pix_we. The same request right after reset, with params_valid=0, loads weights anyway.
- Random in_valid gaps and random win_ack delays → strobe counts and addresses unchanged; win_row/win_col stable until ack.
- STRIDE=2, IMG 8x8, K=3 → OUT_W=3; window coordinates 0,2,4 per row; 9 results.
- Reset asserted mid-LOAD_P and mid-COMPUTE → all outputs 0 within the same cycle; no done pulse; the next start runs a full load.
